// File: rtl/mux16_rr_sched_if.sv
// mux16_rr_sched_if: scheduler handshake bundle; master = scheduler, slave = requesters/consumer.
interface mux16_rr_sched_if;
  logic        en;
  logic        ready;
  logic        valid;
  logic        done;
  logic        timeout;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  sel;
  modport master (input en, req, ready, output sel, valid, grant, done, timeout);
  modport slave (output en, req, ready, input sel, valid, grant, done, timeout);
endinterface

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin select for a shared 16:1 mux; MUX16_SCHED_TIMEOUT_EN adds grant abandonment.
module mux16_rr_sched #(
  parameter int NREQ    = 16,
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  mux16_rr_sched_if.master s
);
  if (NREQ != 16) begin : g_bad_nreq
    $error("mux16_rr_sched: NREQ must be 16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mux16_rr_sched: TIMEOUT must be 1..255");
  end
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state;
  logic [3:0] ptr;
  logic [3:0] nxt;
  function automatic logic [3:0] winner(input logic [3:0] p, input logic [15:0] r);
    winner = p;
    for (int k = 15; k >= 0; k--)
      if (r[p + 4'(k)]) winner = p + 4'(k);
  endfunction
  assign nxt = s.sel + 4'd1;
  assign s.grant = s.valid ? 16'(1) << s.sel : '0;
`ifdef MUX16_SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt;
`else
  assign s.timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      s.sel   <= '0;
      s.valid <= 1'b0;
      s.done  <= 1'b0;
      ptr     <= '0;
`ifdef MUX16_SCHED_TIMEOUT_EN
      s.timeout <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      s.done <= s.valid & s.ready;
`ifdef MUX16_SCHED_TIMEOUT_EN
      s.timeout <= 1'b0;
`endif
      if (state == IDLE) begin
        if (s.en && |s.req) begin
          state   <= GRANT;
          s.sel   <= winner(ptr, s.req);
          s.valid <= 1'b1;
`ifdef MUX16_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
      end else if (s.ready) begin
        ptr <= nxt;
        if (s.en && |s.req) begin
          s.sel <= winner(nxt, s.req);
`ifdef MUX16_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end else begin
          state   <= IDLE;
          s.valid <= 1'b0;
        end
      end else begin
`ifdef MUX16_SCHED_TIMEOUT_EN
        // stalled requester is abandoned and moves to lowest priority
        if (wait_cnt == 8'(TIMEOUT - 1)) begin
          state     <= IDLE;
          s.valid   <= 1'b0;
          ptr       <= nxt;
          s.timeout <= 1'b1;
          wait_cnt  <= '0;
        end else
          wait_cnt <= wait_cnt + 8'd1;
`endif
      end
    end
endmodule
